pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage 64-bit pipeline. Drives the

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Optional STALL_COUNTERS_EN adds stall_cycles/flush_count performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  input  logic       ex_branch_taken,
  input  logic       mem_MemRead,
  input  logic       mem_MemWrite,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       pc_write,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       mem_wb_bubble,
`ifdef STALL_COUNTERS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic       mem_error
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       set_err;
  logic       freeze;
  logic       acc;
  logic       load_use;

  assign acc      = mem_MemRead | mem_MemWrite;
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      mem_error <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (set_err) mem_error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    set_err   = 1'b0;
    freeze    = 1'b0;
    dmem_req  = 1'b0;
    case (state)
      RUN: begin
        dmem_req = acc;
        if (acc && !dmem_ack) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ack) begin
          freeze = 1'b1;
          if (wcnt != 8'hFF) wcnt_nxt = wcnt + 8'd1;
          if (wcnt == TIMEOUT_W) set_err = 1'b1;
        end else begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
    // reset forces the idle pattern, including a same-cycle drop of dmem_req
    if (reset) begin
      freeze   = 1'b0;
      dmem_req = 1'b0;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!reset) begin
      if (freeze) begin
        pc_write      = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef STALL_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write)   stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with per-cycle reference model
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic       ex_MemRead = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_MemRead = 1'b0, mem_MemWrite = 1'b0, dmem_ack = 1'b0;
  logic       dmem_req, pc_write, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_en, mem_wb_bubble, mem_error;
`ifdef STALL_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_write(pc_write), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
`ifdef STALL_COUNTERS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb, bubble;
  } exp_t;

  // reference state: waiting for dmem, cycles spent waiting, sticky error, counters
  bit m_wait = 0;
  int m_waited = 0;
  bit m_err = 0;
  int unsigned m_stall = 0, m_flush = 0;

  function automatic exp_t exp_vec();
    exp_t e;
    bit req, frozen, br, lu;
    req    = !reset && (mem_MemRead || mem_MemWrite || m_wait);
    frozen = req && !dmem_ack;
    br     = !reset && !frozen && ex_branch_taken;
    lu     = !reset && !frozen && !br && ex_MemRead && ex_rd != 0 &&
             (ex_rd == id_rs1 || ex_rd == id_rs2);
    e.req     = req;
    e.pc      = !frozen && !lu;
    e.ifid_en = !frozen && !lu;
    e.ifid_fl = br;
    e.idex_en = !frozen;
    e.idex_fl = br || lu;
    e.exmem   = !frozen;
    e.memwb   = 1'b1;
    e.bubble  = frozen;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    exp_t e;
    if (reset) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      e = exp_vec();
      if (!e.pc) m_stall++;
      if (e.ifid_fl) m_flush++;
      if (e.bubble) begin
        if (m_wait) begin
          m_waited++;
          if (m_waited >= TO) m_err = 1;
        end else begin
          m_wait = 1;
          m_waited = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = exp_vec();
    chk("dmem_req", 32'(dmem_req), 32'(e.req));
    chk("pc_write", 32'(pc_write), 32'(e.pc));
    chk("if_id_en", 32'(if_id_en), 32'(e.ifid_en));
    chk("if_id_flush", 32'(if_id_flush), 32'(e.ifid_fl));
    chk("id_ex_en", 32'(id_ex_en), 32'(e.idex_en));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e.idex_fl));
    chk("ex_mem_en", 32'(ex_mem_en), 32'(e.exmem));
    chk("mem_wb_en", 32'(mem_wb_en), 32'(e.memwb));
    chk("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e.bubble));
    chk("mem_error", 32'(mem_error), 32'(m_err));
`ifdef STALL_COUNTERS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_MemRead = 0; ex_branch_taken = 0;
    mem_MemRead = 0; mem_MemWrite = 0; dmem_ack = 0;
  endtask

  initial begin
    idle();
    mem_MemRead = 1;
    @(negedge clk);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_error", 32'(mem_error), 32'd0);
    cyc();
    reset = 0;
    idle();
    cyc();

    // load-use on rs1
    ex_MemRead = 1; ex_rd = 5; id_rs1 = 5;
    @(negedge clk);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_ex_mem_en", 32'(ex_mem_en), 32'd1);
    cyc();
    ex_MemRead = 0;
    @(negedge clk);
    chk("lu_after_pc_write", 32'(pc_write), 32'd1);
    cyc();

    // x0 never stalls; branch overrides load-use
    ex_MemRead = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    cyc();
    ex_rd = 5; id_rs2 = 5; ex_branch_taken = 1;
    @(negedge clk);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    cyc();
    idle();
    cyc();

    // three wait cycles then ack
    mem_MemRead = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_dmem_req", 32'(dmem_req), 32'd1);
      chk("mw_bubble", 32'(mem_wb_bubble), 32'd1);
      chk("mw_pc_write", 32'(pc_write), 32'd0);
      cyc();
    end
    dmem_ack = 1;
    @(negedge clk);
    chk("ack_dmem_req", 32'(dmem_req), 32'd1);
    chk("ack_pc_write", 32'(pc_write), 32'd1);
    chk("ack_bubble", 32'(mem_wb_bubble), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("post_ack_req", 32'(dmem_req), 32'd0);
    cyc();
`ifdef STALL_COUNTERS_EN
    @(negedge clk);
    chk("lit_stall_cycles", stall_cycles, 32'd4);
    chk("lit_flush_count", flush_count, 32'd1);
    cyc();
`endif

    // zero-wait write
    mem_MemWrite = 1; dmem_ack = 1;
    @(negedge clk);
    chk("zw_dmem_req", 32'(dmem_req), 32'd1);
    chk("zw_pc_write", 32'(pc_write), 32'd1);
    cyc();

    // branch held across freeze, acted on at ack
    idle();
    mem_MemRead = 1; ex_branch_taken = 1;
    @(negedge clk);
    chk("hold_br_flush", 32'(if_id_flush), 32'd0);
    cyc();
    dmem_ack = 1;
    @(negedge clk);
    chk("rel_br_flush", 32'(if_id_flush), 32'd1);
    cyc();
    idle();
    cyc();

    // timeout: error rises after the 4th cycle spent in MEM_WAIT
    mem_MemRead = 1;
    cyc();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("to_err_low", 32'(mem_error), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("to_err_high", 32'(mem_error), 32'd1);
    cyc();
    dmem_ack = 1;
    cyc();
    idle();
    @(negedge clk);
    chk("to_err_sticky", 32'(mem_error), 32'd1);
    cyc();

    // reset in the middle of a wait
    mem_MemRead = 1;
    cyc();
    cyc();
    reset = 1;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_err", 32'(mem_error), 32'd0);
    chk("rst_mid_pc", 32'(pc_write), 32'd1);
    cyc();
    reset = 0;
    mem_MemRead = 0;
    @(negedge clk);
    chk("rst_run_req", 32'(dmem_req), 32'd0);
    chk("rst_run_pc", 32'(pc_write), 32'd1);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
